boot_imem_writer: RTL and testbench

Downstream consumer of the UART bootloader's word stream. Captures each 32-bit word on the bootloader's one-cycle `increment` strobe with its word address, then writes it into instruction memory through a ready/valid write port. Holds the CPU in reset for the whole load window. Keeps a word count, an optional running checksum, and sticky error flags for host-side load verification.

---
 rtl/boot_pkg.sv | 14 +
 rtl/boot_imem_writer.sv | 129 ++++++++++++
 tb/tb_boot_imem_writer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time instruction memory writer.
// Built with optional checksum accumulator under BOOT_CHECKSUM_EN.
package boot_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    WRITE
  } boot_wr_state_t;

  localparam int BOOT_DEPTH = 4096;
  localparam int CSUM_W     = 32;

endpackage

// File: rtl/boot_imem_writer.sv
// Captures bootloader words and writes them into instruction memory.
// Define BOOT_CHECKSUM_EN to build the running checksum accumulator.
module boot_imem_writer
  import boot_pkg::*;
#(
  parameter  int DEPTH = BOOT_DEPTH,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             debug,
  input  logic [31:0]      addr,
  input  logic [31:0]      data,
  input  logic             increment,
  output logic [AW-1:0]    mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic             cpu_rst_n,
  output logic             loading,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      checksum,
  output logic             err_overrun,
  output logic             err_range
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  boot_wr_state_t state;

  logic in_range;
  logic open_win;
  logic accept;

  assign in_range = addr < 32'(DEPTH);
  assign open_win = (state == RUN) && debug;
  assign accept   = (state == WRITE) && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      loading     <= 1'b0;
      word_count  <= '0;
      err_overrun <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          cpu_rst_n <= 1'b1;
          loading   <= 1'b0;
          if (debug) begin
            state       <= LOAD;
            cpu_rst_n   <= 1'b0;
            loading     <= 1'b1;
            word_count  <= '0;
            err_overrun <= 1'b0;
            err_range   <= 1'b0;
          end
        end
        LOAD: begin
          // A strobe wins over debug falling; it cannot be replayed.
          if (increment) begin
            if (in_range) begin
              mem_addr  <= addr[AW-1:0];
              mem_wdata <= data;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              err_range <= 1'b1;
            end
          end else if (!debug) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            loading   <= 1'b0;
          end
        end
        WRITE: begin
          if (increment) begin
            err_overrun <= 1'b1;
          end
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (word_count != CNT_MAX) begin
              word_count <= word_count + 1'b1;
            end
            if (debug) begin
              state <= LOAD;
            end else begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
              loading   <= 1'b0;
            end
          end
        end
        default: begin
          state  <= RUN;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (open_win) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + mem_wdata;
    end
  end

  assign checksum = csum_q;
`else
  logic unused_acc;

  assign unused_acc = open_win ^ accept;
  assign checksum   = 32'h0;
`endif

endmodule

// File: tb/tb_boot_imem_writer.sv
// Self-checking bench for boot_imem_writer: vector table, corner
// sequences, and a randomized load checked against a write queue.
module tb_boot_imem_writer;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          debug;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic          increment;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic          cpu_rst_n;
  logic          loading;
  logic [15:0]   word_count;
  logic [31:0]   checksum;
  logic          err_overrun;
  logic          err_range;

  boot_imem_writer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .debug(debug), .addr(addr),
    .data(data), .increment(increment), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .cpu_rst_n(cpu_rst_n), .loading(loading),
    .word_count(word_count), .checksum(checksum),
    .err_overrun(err_overrun), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cs(input logic [31:0] s);
    return CS_EN ? s : 32'h0;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
    chk({tag, " loading"}, 32'(loading), 32'h0);
    chk({tag, " word_count"}, 32'(word_count), 32'h0);
    chk({tag, " checksum"}, checksum, 32'h0);
    chk({tag, " err_overrun"}, 32'(err_overrun), 32'h0);
    chk({tag, " err_range"}, 32'(err_range), 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    bit          we;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  vec_t        tbl[6];
  wr_t         exp_q[$];
  int          exp_cnt;
  logic [31:0] exp_sum;
  bit          exp_rng;

  initial begin
    tbl[0] = '{32'd0, 32'h11111111, 0, 1'b1};
    tbl[1] = '{32'd1, 32'h22222222, 0, 1'b1};
    tbl[2] = '{32'd2, 32'h33333333, 0, 1'b1};
    tbl[3] = '{32'd3, 32'hA5A5_5A5A, 5, 1'b1};
    tbl[4] = '{32'(DEPTH), 32'hDEAD_BEEF, 0, 1'b0};
    tbl[5] = '{32'(DEPTH - 1), 32'hCAFE_F00D, 2, 1'b1};

    rst_n = 1'b0; debug = 1'b0; addr = '0; data = '0;
    increment = 1'b0; mem_ready = 1'b0;
    repeat (2) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk("run cpu_rst_n", 32'(cpu_rst_n), 32'h1);

    // Vector table: opens window, loads words, drops debug.
    debug = 1'b1;
    step();
    chk("load cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("load loading", 32'(loading), 32'h1);
    exp_cnt = 0; exp_sum = '0; exp_rng = 1'b0;
    foreach (tbl[i]) begin
      addr = tbl[i].addr; data = tbl[i].data;
      increment = 1'b1; mem_ready = (tbl[i].hold == 0);
      step();
      increment = 1'b0;
      if (!tbl[i].we) exp_rng = 1'b1;
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("v%0d err_range", i), 32'(err_range), 32'(exp_rng));
      if (tbl[i].we) begin
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr),
            32'(tbl[i].addr[AW-1:0]));
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].data);
      end
      for (int w = 0; w < tbl[i].hold; w++) begin
        step();
        chk($sformatf("v%0d hold we", i), 32'(mem_we), 32'h1);
        chk($sformatf("v%0d hold data", i), mem_wdata, tbl[i].data);
        chk($sformatf("v%0d hold cnt", i), 32'(word_count), 32'(exp_cnt));
      end
      mem_ready = 1'b1;
      step();
      if (tbl[i].we) begin
        exp_cnt++;
        exp_sum += tbl[i].data;
      end
      chk($sformatf("v%0d post we", i), 32'(mem_we), 32'h0);
      chk($sformatf("v%0d count", i), 32'(word_count), 32'(exp_cnt));
      chk($sformatf("v%0d checksum", i), checksum, exp_cs(exp_sum));
      if (i == 2) begin
        chk("three word sum", checksum, exp_cs(32'h66666666));
        chk("three word count", 32'(word_count), 32'd3);
      end
      chk($sformatf("v%0d cpu held", i), 32'(cpu_rst_n), 32'h0);
    end
    debug = 1'b0;
    step();
    chk("drop cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("drop loading", 32'(loading), 32'h0);
    chk("drop keeps range", 32'(err_range), 32'h1);

    // Reopening the window clears counters and flags.
    debug = 1'b1;
    step();
    chk("reopen err_range", 32'(err_range), 32'h0);
    chk("reopen count", 32'(word_count), 32'h0);
    chk("reopen checksum", checksum, 32'h0);

    // Overrun: second strobe while the first write is pending.
    mem_ready = 1'b0;
    addr = 32'd10; data = 32'h0000_AAAA; increment = 1'b1;
    step();
    addr = 32'd11; data = 32'h0000_BBBB;
    step();
    increment = 1'b0;
    chk("ovr flag", 32'(err_overrun), 32'h1);
    chk("ovr addr", 32'(mem_addr), 32'd10);
    chk("ovr data", mem_wdata, 32'h0000_AAAA);
    mem_ready = 1'b1;
    step();
    chk("ovr accept we", 32'(mem_we), 32'h0);
    chk("ovr count", 32'(word_count), 32'd1);
    repeat (3) begin
      step();
      chk("ovr no 2nd write", 32'(mem_we), 32'h0);
    end
    chk("ovr checksum", checksum, exp_cs(32'h0000_AAAA));

    // debug falls together with the strobe: write still completes.
    mem_ready = 1'b0;
    addr = 32'd20; data = 32'h1234_5678; increment = 1'b1; debug = 1'b0;
    step();
    increment = 1'b0;
    chk("fall we", 32'(mem_we), 32'h1);
    chk("fall cpu held", 32'(cpu_rst_n), 32'h0);
    step();
    chk("fall pending", 32'(mem_we), 32'h1);
    chk("fall addr", 32'(mem_addr), 32'd20);
    mem_ready = 1'b1;
    step();
    chk("fall accept we", 32'(mem_we), 32'h0);
    chk("fall cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("fall loading", 32'(loading), 32'h0);
    chk("fall count", 32'(word_count), 32'd2);

    // Reset asserted mid-write.
    debug = 1'b1;
    step();
    mem_ready = 1'b0;
    addr = 32'd30; data = 32'hFFFF_0001; increment = 1'b1;
    step();
    increment = 1'b0;
    chk("rst pre we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    debug = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst release cpu", 32'(cpu_rst_n), 32'h1);
    chk("rst release we", 32'(mem_we), 32'h0);

    // Randomized load against a queue of expected writes.
    debug = 1'b1;
    step();
    exp_q = {}; exp_cnt = 0; exp_sum = '0; exp_rng = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bit oor;
      bit done;
      oor = ($urandom_range(0, 4) == 0);
      addr = oor ? 32'(DEPTH) + $urandom_range(0, 1000)
                 : 32'($urandom_range(0, DEPTH - 1));
      data = $urandom;
      increment = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      if (oor) exp_rng = 1'b1;
      else exp_q.push_back('{addr[AW-1:0], data});
      step();
      increment = 1'b0;
      if (oor) begin
        chk("rnd oor no we", 32'(mem_we), 32'h0);
      end else begin
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
          if (c > 0) mem_ready = 1'($urandom_range(0, 1));
          if (c == 59) mem_ready = 1'b1;
          if (mem_we && mem_ready) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("rnd wr addr", 32'(mem_addr), 32'(e.addr));
            chk("rnd wr data", mem_wdata, e.data);
            exp_cnt++;
            exp_sum += e.data;
            done = 1'b1;
          end
          step();
        end
        if (!done) chk("rnd write timeout", 32'h0, 32'h1);
      end
      repeat ($urandom_range(0, 3)) begin
        mem_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    chk("rnd count", 32'(word_count), 32'(exp_cnt));
    chk("rnd checksum", checksum, exp_cs(exp_sum));
    chk("rnd err_range", 32'(err_range), 32'(exp_rng));
    chk("rnd err_overrun", 32'(err_overrun), 32'h0);
    chk("rnd queue empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
